// File: rtl/fp_norm_pack.sv
// Post-adder normalizer/packer: renormalizes a raw {carry, hidden, fraction} mantissa one bit
// per cycle and emits a packed IEEE-754 single with zero/overflow/underflow flags.
module fp_norm_pack #(
    parameter int unsigned MANT_W = 25,
    parameter int unsigned EXP_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [MANT_W-1:0]         in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W-2:0]   data_o,
    output logic                      out_zero,
    output logic                      out_ovf,
    output logic                      out_unf
);

    localparam int unsigned FRAC_W = MANT_W - 2;
    localparam logic [EXP_W-1:0] ExpMax = '1;
    localparam logic [EXP_W-1:0] ExpSat = ExpMax - EXP_W'(1);
    localparam logic [EXP_W-1:0] ExpOne = EXP_W'(1);

    typedef enum logic [1:0] {StIdle, StNorm, StDone} stateT;

    stateT                    stateQ;
    logic                     signQ;
    logic [EXP_W-1:0]         expQ;
    logic [MANT_W-1:0]        mantQ;
    logic                     inReadyQ;
    logic                     outValidQ;
    logic [EXP_W+FRAC_W:0]    dataQ;
    logic                     zeroQ;
    logic                     ovfQ;
    logic                     unfQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            signQ     <= 1'b0;
            expQ      <= '0;
            mantQ     <= '0;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            dataQ     <= '0;
            zeroQ     <= 1'b0;
            ovfQ      <= 1'b0;
            unfQ      <= 1'b0;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (in_valid) begin
                        signQ    <= in_sign;
                        expQ     <= in_exp;
                        mantQ    <= in_mant;
                        inReadyQ <= 1'b0;
                        stateQ   <= StNorm;
                    end
                end
                StNorm: begin
                    // Decisions are strictly prioritized; only the final branch loops.
                    if (expQ == ExpMax) begin
                        dataQ     <= {signQ, ExpMax, {FRAC_W{1'b0}}};
                        ovfQ      <= 1'b1;
                        outValidQ <= 1'b1;
                        stateQ    <= StDone;
                    end else if (mantQ == '0) begin
                        dataQ     <= '0;
                        zeroQ     <= 1'b1;
                        outValidQ <= 1'b1;
                        stateQ    <= StDone;
                    end else if (mantQ[MANT_W-1]) begin
                        if (expQ >= ExpSat) begin
                            dataQ <= {signQ, ExpMax, {FRAC_W{1'b0}}};
                            ovfQ  <= 1'b1;
                        end else begin
                            mantQ <= mantQ >> 1;
                            expQ  <= expQ + ExpOne;
                            dataQ <= {signQ, expQ + ExpOne, mantQ[FRAC_W:1]};
                        end
                        outValidQ <= 1'b1;
                        stateQ    <= StDone;
                    end else if (mantQ[MANT_W-2]) begin
                        dataQ     <= {signQ, expQ, mantQ[FRAC_W-1:0]};
                        outValidQ <= 1'b1;
                        stateQ    <= StDone;
                    end else if (expQ <= ExpOne) begin
                        dataQ     <= {signQ, {(EXP_W+FRAC_W){1'b0}}};
                        unfQ      <= 1'b1;
                        outValidQ <= 1'b1;
                        stateQ    <= StDone;
                    end else begin
                        mantQ <= mantQ << 1;
                        expQ  <= expQ - ExpOne;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        outValidQ <= 1'b0;
                        zeroQ     <= 1'b0;
                        ovfQ      <= 1'b0;
                        unfQ      <= 1'b0;
                        inReadyQ  <= 1'b1;
                        stateQ    <= StIdle;
                    end
                end
                default: begin
                    inReadyQ  <= 1'b1;
                    outValidQ <= 1'b0;
                    stateQ    <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = inReadyQ;
    assign out_valid = outValidQ;
    assign data_o    = dataQ;
    assign out_zero  = zeroQ;
    assign out_ovf   = ovfQ;
    assign out_unf   = unfQ;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed self-checking bench for fp_norm_pack with hand-computed expected results.
module tb_fp_norm_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_o;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int tests;
    int fails;

    fp_norm_pack #(.MANT_W(25), .EXP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand across a single edge, then scramble the inputs.
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_exp   = 8'($urandom);
        in_mant  = 25'($urandom);
    endtask

    // Edges from accept (inclusive) until out_valid is seen; -1 if it never rises.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) edges = -1;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, data_o, out_zero, out_ovf, out_unf} !== {1'b1, 1'b0, 32'h0, 3'b0})
        begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b data=%h flags=%b, want 1 0 0 000",
                     in_ready, out_valid, data_o, {out_zero, out_ovf, out_unf});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_case(input string name, input logic s, input logic [7:0] e,
                            input logic [24:0] m, input logic [31:0] expData,
                            input logic [2:0] expFlags, input int expEdges);
        int edges;
        send(s, e, m);
        wait_valid(edges);
        tests++;
        if (edges !== expEdges) begin
            fails++;
            $display("FAIL %s latency: got %0d edges, want %0d", name, edges, expEdges);
        end
        tests++;
        if (data_o !== expData) begin
            fails++;
            $display("FAIL %s data: got %h, want %h", name, data_o, expData);
        end
        tests++;
        if ({out_zero, out_ovf, out_unf} !== expFlags) begin
            fails++;
            $display("FAIL %s flags: got %b, want %b", name, {out_zero, out_ovf, out_unf}, expFlags);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s in_ready in DONE: got %b, want 0", name, in_ready);
        end
    endtask

    task automatic test_normalized();
        run_case("normalized", 1'b0, 8'h7F, 25'h0C00000, 32'h3FC00000, 3'b000, 2);
        release_result();
    endtask

    task automatic test_carry();
        run_case("carry", 1'b0, 8'h7F, 25'h1800000, 32'h40400000, 3'b000, 2);
        release_result();
    endtask

    task automatic test_cancel();
        run_case("cancel", 1'b0, 8'h80, 25'h0000001, 32'h34800000, 3'b000, 25);
        release_result();
    endtask

    task automatic test_zero_ovf();
        run_case("zero", 1'b1, 8'h85, 25'h0000000, 32'h00000000, 3'b100, 2);
        release_result();
        run_case("carry_ovf", 1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b010, 2);
        release_result();
        run_case("exp_ff", 1'b1, 8'hFF, 25'h0C00000, 32'hFF800000, 3'b010, 2);
        release_result();
    endtask

    task automatic test_underflow_backpressure();
        run_case("underflow", 1'b1, 8'h03, 25'h0100000, 32'h80000000, 3'b001, 4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({out_valid, in_ready, data_o, out_zero, out_ovf, out_unf} !==
                {1'b1, 1'b0, 32'h80000000, 3'b001}) begin
                fails++;
                $display("FAIL hold cycle %0d: valid=%b in_ready=%b data=%h flags=%b", i,
                         out_valid, in_ready, data_o, {out_zero, out_ovf, out_unf});
            end
        end
        release_result();
        tests++;
        if ({out_valid, in_ready, out_zero, out_ovf, out_unf} !== {1'b0, 1'b1, 3'b000}) begin
            fails++;
            $display("FAIL release: valid=%b in_ready=%b flags=%b, want 0 1 000",
                     out_valid, in_ready, {out_zero, out_ovf, out_unf});
        end
    endtask

    task automatic test_reset_midop();
        send(1'b0, 8'h80, 25'h0000001);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, data_o} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL midop reset: in_ready=%b valid=%b data=%h, want 1 0 0",
                     in_ready, out_valid, data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL discarded op: out_valid=%b, want 0", out_valid);
        end
        run_case("after_reset", 1'b1, 8'h7F, 25'h0C00000, 32'hBFC00000, 3'b000, 2);
        release_result();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h0;
        in_mant   = 25'h0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_normalized();
        test_carry();
        test_cancel();
        test_zero_ovf();
        test_underflow_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_norm_pack.md
Name: fp_norm_pack

Overview:
Sequential post-adder normalizer and packer. It sits directly downstream of the floating-point add/sub stage in the FP square-root datapath, which produces a raw sign, an exponent (that of the larger operand) and an unnormalized 25-bit mantissa sum with carry.
The block renormalizes iteratively, one bit per cycle. It handles carry-out, cancellation, zero, overflow and underflow, and emits a packed IEEE-754 single behind a valid/ready handshake.

Parameters:
MANT_W, 25, raw mantissa width: bit 24 = carry, bit 23 = hidden bit, bits 22:0 = fraction.
EXP_W, 8, exponent width.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
in_valid  input  1  raw operand present.
in_ready  output  1  block can accept an operand; high only in IDLE.
in_sign  input  1  raw result sign.
in_exp  input  8  raw biased exponent.
in_mant  input  25  raw mantissa {carry, hidden, fraction}.
out_valid  output  1  data_o and flags valid.
out_ready  input  1  consumer accepts the result.
data_o  output  32  packed result {sign, exp[7:0], frac[22:0]}.
out_zero  output  1  result is zero (exact cancellation or zero input).
out_ovf  output  1  result saturated to infinity.
out_unf  output  1  result flushed to zero (subnormal territory).

Behaviour:
- Reset (rst_n=0 at an edge):
  - state to IDLE.
  - in_ready=1, out_valid=0, data_o=0, all flags 0.
  - Internal sign/exp/mant registers to 0.
  - Reset mid-operation discards the in-flight operand; no output is produced for it.
- States: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge, latch sign/exp/mant and go to NORM.
- NORM: one decision per cycle, evaluated in priority order:
  1. exp==255: result {sign,8'hFF,23'b0}, out_ovf=1, go to DONE.
  2. mant==0: result 32'h00000000 (sign forced 0), out_zero=1, go to DONE.
  3. mant[24]=1:
     - if exp>=254: result {sign,8'hFF,0}, out_ovf=1.
     - else mant>>=1 (LSB truncated, no rounding), exp+=1, pack.
     - Go to DONE.
  4. mant[23]=1: pack {sign, exp, mant[22:0]}, go to DONE.
  5. exp<=1: result {sign,31'b0}, out_unf=1, go to DONE.
  6. Otherwise: mant<<=1, exp-=1, stay in NORM.
- DONE:
  - out_valid=1; data_o and flags held stable.
  - On out_ready=1 at an edge: out_valid to 0, flags cleared, go to IDLE.
  - in_ready is 0 throughout DONE; no accept in the same cycle as a result handoff.
- Latency:
  - Handshake at edge T; out_valid is high from the cycle after edge T+1+k, where k = number of left shifts (0..23).
  - Normalized or carry input: out_valid 2 edges after accept.
  - Worst-case cancellation (k=23): 25 edges.
- Throughput: one operand in flight at a time.
- Exponent arithmetic: 8-bit unsigned.
  - Decrement never goes below 1, because the exp<=1 check precedes the shift.
  - Increment is guarded by the >=254 check.
- Hidden bit is never stored in data_o; fraction = mant[22:0] after normalization.
- in_* inputs are ignored outside IDLE; they may change freely.
- out_ready is ignored outside DONE.

Test Plan:
- Normalized: sign=0, exp=8'h7F, mant=25'h0C00000 -> data_o=32'h3FC00000, flags 0, out_valid 2 edges after accept.
- Carry: sign=0, exp=8'h7F, mant=25'h1800000 -> data_o=32'h40400000 (exp 8'h80, frac 23'h400000), 2 edges.
- Cancellation: sign=0, exp=8'h80, mant=25'h0000001 -> 23 left shifts, data_o=32'h34800000, out_valid 25 edges after accept.
- Zero and overflow:
  - exp=8'h85, mant=0 -> data_o=32'h00000000, out_zero=1.
  - exp=8'hFE, mant=25'h1000000 -> data_o=32'h7F800000, out_ovf=1.
- Underflow plus backpressure:
  - sign=1, exp=8'h03, mant=25'h0100000 -> data_o=32'h80000000, out_unf=1.
  - Hold out_ready=0 for 5 cycles: out_valid, data_o and flags stay stable and in_ready stays 0.
  - Release: back to IDLE next edge.
- Reset mid-op: accept exp=8'h80, mant=25'h0000001; assert rst_n=0 after 5 cycles -> next edge in_ready=1, out_valid=0, data_o=0; a new operand is then accepted and processed correctly.
